// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared note table, half-period helper and sequencer state type
package tone_pkg;

  typedef logic [3:0] note_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    FIN  = 2'd2
  } seq_state_t;

  localparam int unsigned NUM_NOTES = 15;

  // Hz per note code: C4..C5, Bb4, A3, D5..A5; code 0 is a rest
  localparam int unsigned FREQ [16] = '{
    0, 262, 294, 330, 349, 392, 440, 494,
    523, 466, 220, 587, 659, 698, 784, 880
  };

  function automatic int unsigned half(input int unsigned clk_hz, input int unsigned code);
    int unsigned h;
    h = 1;
    if (code >= 1 && code <= NUM_NOTES) begin
      h = clk_hz / (2 * FREQ[code]);
    end
    if (h == 0) begin
      h = 1;
    end
    return h;
  endfunction

endpackage

// File: rtl/tone_osc.sv
// rtl/tone_osc.sv - free-running square-wave oscillator, toggles every HALF_CYC clocks
module tone_osc #(
  parameter int unsigned HALF_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tone
);

  localparam int unsigned CW = (HALF_CYC < 2) ? 1 : $clog2(HALF_CYC);
  localparam logic [CW-1:0] TERM = CW'(HALF_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tone_d = tone_q;
    if (cnt_q == TERM) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - key-gated tones plus song RAM player on a shared oscillator bank
// Optional: TONE_SEQ_ARTIC_EN inserts a short silence at the end of every song step.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned NUM_KEYS   = 8,
  parameter int unsigned SONG_DEPTH = 256,
  parameter int unsigned TEMPO_W    = 24,
  localparam int unsigned AW        = $clog2(SONG_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                song_mode,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [3:0]          wr_data,
  input  logic [AW:0]         song_len,
  input  logic [TEMPO_W-1:0]  tempo_div,
  input  logic                loop,
  input  logic                start,
  input  logic                stop,
  output logic [NUM_KEYS-1:0] key_out,
  output logic                song_out,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       step_idx
);

  if (NUM_KEYS > NUM_NOTES || NUM_KEYS == 0) begin : g_bad_keys
    $error("tone_sequencer: NUM_KEYS must be in 1..15");
  end

  logic [15:0] osc;
  assign osc[0] = 1'b0;

  for (genvar c = 1; c <= NUM_NOTES; c++) begin : g_osc
    tone_osc #(.HALF_CYC(half(CLK_HZ, c))) u_osc (
      .clk  (clk),
      .rst_n(rst_n),
      .tone (osc[c])
    );
  end

  seq_state_t          state_q, state_d;
  logic [AW-1:0]       step_q, step_d;
  logic [TEMPO_W-1:0]  cnt_q, cnt_d;
  logic [TEMPO_W-1:0]  tdiv_q, tdiv_d;
  logic [AW:0]         len_q, len_d;
  note_code_t          rd_q, rd_d;
  logic [NUM_KEYS-1:0] key_q, key_d;
  logic                song_q, song_d;

  note_code_t ram [SONG_DEPTH];

  logic start_ok, last_tick, last_step, gap;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    tdiv_d    = tdiv_q;
    len_d     = len_q;
    start_ok  = start && (song_len != '0);
    last_tick = (cnt_q == tdiv_q - TEMPO_W'(1));
    last_step = ({1'b0, step_q} == len_q - (AW+1)'(1));

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = PLAY;
          step_d  = '0;
          cnt_d   = '0;
          len_d   = song_len;
          tdiv_d  = (tempo_div == '0) ? TEMPO_W'(1) : tempo_div;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          step_d  = '0;
          cnt_d   = '0;
        end else if (start_ok) begin
          step_d  = '0;
          cnt_d   = '0;
          len_d   = song_len;
          tdiv_d  = (tempo_div == '0) ? TEMPO_W'(1) : tempo_div;
        end else if (last_tick) begin
          cnt_d = '0;
          if (!last_step) begin
            step_d = step_q + AW'(1);
          end else begin
            step_d = '0;
            if (!loop) begin
              state_d = FIN;
            end
          end
        end else begin
          cnt_d = cnt_q + TEMPO_W'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Leaving song mode abandons playback without a done pulse
    if (!song_mode) begin
      state_d = IDLE;
      step_d  = '0;
      cnt_d   = '0;
    end
  end

`ifdef TONE_SEQ_ARTIC_EN
  assign gap = (cnt_q >= tdiv_q - (tdiv_q >> 3));
`else
  assign gap = 1'b0;
`endif

  // Reading at the next step index keeps the RAM word aligned with step_q
  always_comb begin
    rd_d   = ram[step_d];
    key_d  = song_mode ? '0 : (keys & osc[NUM_KEYS:1]);
    song_d = 1'b0;
    if (song_mode && state_q == PLAY && !gap) begin
      song_d = osc[rd_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && state_q == IDLE) begin
      ram[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      tdiv_q  <= '0;
      len_q   <= '0;
      rd_q    <= '0;
      key_q   <= '0;
      song_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      tdiv_q  <= tdiv_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      key_q   <= key_d;
      song_q  <= song_d;
    end
  end

  assign key_out  = key_q;
  assign song_out = song_q;
  assign busy     = (state_q == PLAY);
  assign done     = (state_q == FIN);
  assign step_idx = step_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - randomized self-checking bench for tone_sequencer against a timeline model
module tb_tone_sequencer;

  localparam int CLK_HZ = 8000;
  localparam int NK     = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int TW     = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          song_mode = 1'b0;
  logic [NK-1:0] keys = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0]    wr_data = '0;
  logic [AW:0]   song_len = '0;
  logic [TW-1:0] tempo_div = '0;
  logic          loop = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [NK-1:0] key_out;
  logic          song_out;
  logic          busy;
  logic          done;
  logic [AW-1:0] step_idx;

  tone_sequencer #(
    .CLK_HZ(CLK_HZ), .NUM_KEYS(NK), .SONG_DEPTH(DEPTH), .TEMPO_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .song_mode(song_mode), .keys(keys),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .song_len(song_len), .tempo_div(tempo_div), .loop(loop),
    .start(start), .stop(stop), .key_out(key_out), .song_out(song_out),
    .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: edges since reset release, song timeline anchored at its start edge
  int freq [16] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 466, 220, 587, 659, 698, 784, 880};
  int mram [DEPTH];
  int k = 0;
  bit m_play = 0, m_fin = 0;
  int m_e = 0, m_t = 1, m_len = 1;
  int done_cnt = 0, done_k = 0;

  function automatic bit osc_m(int code, int n);
    int h;
    h = CLK_HZ / (2 * freq[code]);
    if (h < 1) h = 1;
    return ((n / h) % 2) == 1;
  endfunction

  function automatic bit gap_m(int cnt, int t);
`ifdef TONE_SEQ_ARTIC_EN
    return cnt >= t - (t >> 3);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [NK-1:0] e_key;
    logic e_song;
    int el, n, e_step;
    e_key = '0;
    e_song = 1'b0;
    if (!song_mode)
      for (int i = 0; i < NK; i++) e_key[i] = keys[i] & osc_m(i + 1, k);
    if (song_mode && m_play) begin
      el = k - m_e;
      if (mram[(el / m_t) % m_len] != 0 && !gap_m(el % m_t, m_t))
        e_song = osc_m(mram[(el / m_t) % m_len], k);
    end
    if (wr_en && !m_play && !m_fin) mram[wr_addr] = int'(wr_data);
    n = k + 1;
    if (!song_mode) begin
      m_play = 0; m_fin = 0;
    end else if (m_play) begin
      if (stop) m_play = 0;
      else if (start && song_len != 0) begin
        m_e = n; m_len = int'(song_len); m_t = (tempo_div == 0) ? 1 : int'(tempo_div);
      end else if (!loop && ((n - m_e) % (m_len * m_t)) == 0) begin
        m_play = 0; m_fin = 1;
      end
    end else if (m_fin) begin
      m_fin = 0;
    end else if (start && song_len != 0) begin
      m_play = 1; m_e = n; m_len = int'(song_len); m_t = (tempo_div == 0) ? 1 : int'(tempo_div);
    end
    e_step = m_play ? ((n - m_e) / m_t) % m_len : 0;
    @(posedge clk);
    k = n;
    #1;
    chk("key_out", 32'(key_out), 32'(e_key));
    chk("song_out", 32'(song_out), 32'(e_song));
    chk("busy", 32'(busy), 32'(m_play));
    chk("done", 32'(done), 32'(m_fin));
    chk("step_idx", 32'(step_idx), 32'(e_step));
    if (done === 1'b1) begin
      done_cnt++;
      done_k = k;
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic wr(input int addr, input int data);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = 4'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_key_out"}, 32'(key_out), 32'd0);
    chk({tag, "_song_out"}, 32'(song_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_step_idx"}, 32'(step_idx), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    k = 0; m_play = 0; m_fin = 0;
  endtask

  initial begin
    int start_k, len, t;
    for (int i = 0; i < DEPTH; i++) mram[i] = 0;

    #12;
    check_all_zero("reset");
    release_reset();
    for (int i = 0; i < DEPTH; i++) wr(i, 0);

    // Key mode: two fixed keys, then random key patterns
    keys = 8'b0000_0101;
    run(70);
    for (int i = 0; i < 40; i++) begin
      keys = NK'($urandom);
      tick();
    end

    // Single-shot song {1,0,5}
    wr(0, 1); wr(1, 0); wr(2, 5);
    song_mode = 1'b1; song_len = 3; tempo_div = 10; loop = 1'b0;
    done_cnt = 0;
    start_k = k;
    pulse_start();
    run(40);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_latency", 32'(done_k - start_k), 32'd31);

    // Looping song, stop during step 1 of the second pass
    loop = 1'b1; done_cnt = 0;
    pulse_start();
    run(44);
    chk("loop_step_before_stop", 32'(step_idx), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    run(3);
    chk("loop_no_done", 32'(done_cnt), 32'd0);

    // Restart mid-play, dropped write, then start+stop together
    pulse_start();
    run(5);
    wr(1, 7);
    run(4);
    pulse_start();
    run(3);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    run(2);
    loop = 1'b0; tempo_div = 3;
    pulse_start();
    run(12);

    // Zero song length is ignored; zero tempo gives one-clock steps
    song_len = 0;
    pulse_start();
    run(3);
    wr(3, 9);
    song_len = 4; tempo_div = 0;
    pulse_start();
    run(8);

    // Random songs with random tempo and loop, keys churning underneath
    for (int s = 0; s < 5; s++) begin
      len = $urandom_range(1, DEPTH);
      t = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) wr(i, $urandom_range(0, 15));
      song_len = (AW+1)'(len); tempo_div = TW'(t); loop = 1'($urandom_range(0, 1));
      pulse_start();
      for (int i = 0; i < len * t + 6; i++) begin
        keys = NK'($urandom);
        tick();
      end
      stop = 1'b1; tick(); stop = 1'b0;
      tick();
    end

    // Leaving song mode mid-play
    loop = 1'b0; song_len = 3; tempo_div = 10; done_cnt = 0;
    pulse_start();
    run(5);
    song_mode = 1'b0;
    run(15);
    chk("mode_exit_no_done", 32'(done_cnt), 32'd0);

`ifdef TONE_SEQ_ARTIC_EN
    song_mode = 1'b1;
    wr(0, 3); wr(1, 3);
    song_len = 2; tempo_div = 16;
    pulse_start();
    run(36);
`endif

    // Asynchronous reset in the middle of a step
    song_mode = 1'b1; song_len = 3; tempo_div = 10; loop = 1'b1;
    wr(0, 1); wr(1, 5); wr(2, 8);
    pulse_start();
    run(15);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    release_reset();
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
